// File: rtl/stack_drain.sv
// Debug-side stack reader: passes CPU stack traffic through while tracking depth,
// and on request stalls the CPU and destructively streams the stack out top-first.
module stack_drain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_delta,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_stall,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd,
    input  logic [WIDTH-1:0] stk_rd,
    input  logic             drain_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] depth,
    output logic             ovf,
    output logic             unf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_OFFER = 3'd2,
        S_POP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_depth;
    logic [CNT_W-1:0] w_depth_nxt;
    logic [CNT_W-1:0] w_idle_depth;
    logic [CNT_W:0]   w_delta_ext;
    logic [CNT_W:0]   w_sum;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;

    // Saturating depth for the CPU delta; the extra top bit flags a negative result
    always_comb begin
        w_delta_ext  = {{(CNT_W-1){cpu_delta[1]}}, cpu_delta};
        w_sum        = {1'b0, r_depth} + w_delta_ext;
        w_idle_depth = r_depth;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (w_sum[CNT_W]) begin
            w_idle_depth = {CNT_W{1'b0}};
            w_set_unf    = 1'b1;
        end else if ((cpu_delta == 2'b01) && (r_depth == DEPTH_C)) begin
            w_idle_depth = r_depth;
            w_set_ovf    = 1'b1;
        end else begin
            w_idle_depth = w_sum[CNT_W-1:0];
        end
    end

    // Next-state, depth and sticky-flag logic
    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        case (r_state)
            S_IDLE: begin
                w_depth_nxt = w_idle_depth;
                w_ovf_nxt   = r_ovf | w_set_ovf;
                w_unf_nxt   = r_unf | w_set_unf;
                if (!drain_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_idle_depth == {CNT_W{1'b0}}) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_OFFER;
            end
            S_OFFER: begin
                if (out_ready) begin
                    w_state_nxt = S_POP;
                end else begin
                    w_state_nxt = S_OFFER;
                end
            end
            S_POP: begin
                w_depth_nxt = r_depth - ONE_C;
                if (r_depth == ONE_C) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_DONE: begin
                w_ovf_nxt   = 1'b0;
                w_unf_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered status/stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_depth     <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_ovf       <= w_ovf_nxt;
            r_unf       <= w_unf_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_out_valid <= (w_state_nxt == S_OFFER);
            r_out_last  <= (w_state_nxt == S_OFFER) && (w_depth_nxt == ONE_C);
            if (r_state == S_READ) begin
                r_out_data <= stk_rd;
            end else begin
                r_out_data <= r_out_data;
            end
        end
    end

    // Stack port: transparent in IDLE, otherwise owned by the drain engine
    always_comb begin
        stk_we    = 1'b0;
        stk_delta = 2'b00;
        stk_wd    = {WIDTH{1'b0}};
        case (r_state)
            S_IDLE: begin
                stk_we    = cpu_we;
                stk_delta = cpu_delta;
                stk_wd    = cpu_wd;
            end
            S_POP: begin
                stk_delta = 2'b11;
            end
            default: begin
                stk_delta = 2'b00;
            end
        endcase
    end

    assign cpu_rd    = stk_rd;
    assign cpu_stall = r_busy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign depth     = r_depth;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_stack_drain.sv
// Directed bench for stack_drain with a small behavioural stack RAM attached.
module tb_stack_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_delta = 2'b00;
    logic [15:0] cpu_wd = 16'h0000;
    logic [15:0] cpu_rd;
    logic        cpu_stall;
    logic        stk_we;
    logic [1:0]  stk_delta;
    logic [15:0] stk_wd;
    logic [15:0] stk_rd;
    logic        drain_req = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;

    int n_cmp = 0;
    int n_err = 0;

    stack_drain #(.WIDTH(16), .DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .cpu_stall(cpu_stall),
        .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
        .drain_req(drain_req), .busy(busy), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Behavioural stack: pointer moves by the signed delta, write lands at the new top
    logic [15:0] mem [0:7];
    logic [2:0]  sp;
    logic [2:0]  sp_nxt;
    assign sp_nxt = sp + {stk_delta[1], stk_delta};
    assign stk_rd = mem[sp];
    always @(posedge clk or posedge rst) begin
        if (rst) sp <= 3'd0;
        else     sp <= sp_nxt;
    end
    always @(posedge clk) begin
        if (!rst && stk_we) mem[sp_nxt] <= stk_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        cpu_we = 1'b1; cpu_delta = 2'b01; cpu_wd = v;
        tick();
        cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
    endtask

    task automatic cpu_pop(input logic [1:0] d);
        cpu_delta = d;
        tick();
        cpu_delta = 2'b00;
    endtask

    task automatic start_drain();
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if ({busy, done, out_valid, out_last, cpu_stall, ovf, unf} !== 7'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, out_valid, out_last, cpu_stall, ovf, unf});
        end
        n_cmp++; if (depth !== 3'd0) begin n_err++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h expected 0000", out_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_drain3();
        logic [15:0] got [0:3];
        logic        lst [0:3];
        int nb = 0;
        int done_k = -1;
        push(16'h1111); push(16'h2222); push(16'h3333);
        n_cmp++; if (depth !== 3'd3) begin n_err++; $display("FAIL drain3_depth_pre: got %0d expected 3", depth); end
        out_ready = 1'b1;
        start_drain();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++; if (cpu_stall !== (k <= 10)) begin
                n_err++; $display("FAIL drain3_stall k=%0d: got %b expected %b", k, cpu_stall, (k <= 10));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && nb < 4) begin got[nb] = out_data; lst[nb] = out_last; nb++; end
            if (done === 1'b1 && done_k < 0) done_k = k;
            tick();
        end
        n_cmp++; if (nb !== 3) begin n_err++; $display("FAIL drain3_count: got %0d expected 3", nb); end
        n_cmp++; if ({got[0], got[1], got[2]} !== {16'h3333, 16'h2222, 16'h1111}) begin
            n_err++; $display("FAIL drain3_data: got %h %h %h expected 3333 2222 1111", got[0], got[1], got[2]);
        end
        n_cmp++; if ({lst[0], lst[1], lst[2]} !== 3'b001) begin
            n_err++; $display("FAIL drain3_last: got %b%b%b expected 001", lst[0], lst[1], lst[2]);
        end
        n_cmp++; if (done_k !== 10) begin n_err++; $display("FAIL drain3_done_cycle: got %0d expected 10", done_k); end
        n_cmp++; if (depth !== 3'd0) begin n_err++; $display("FAIL drain3_depth_post: got %0d expected 0", depth); end
    endtask

    task automatic test_empty_drain();
        int busy_n = 0;
        int done_k = -1;
        int valid_n = 0;
        start_drain();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (out_valid === 1'b1) valid_n++;
            if (done === 1'b1 && done_k < 0) done_k = k;
            tick();
        end
        n_cmp++; if (busy_n !== 1) begin n_err++; $display("FAIL empty_busy_cycles: got %0d expected 1", busy_n); end
        n_cmp++; if (done_k !== 1) begin n_err++; $display("FAIL empty_done_cycle: got %0d expected 1", done_k); end
        n_cmp++; if (valid_n !== 0) begin n_err++; $display("FAIL empty_valid: got %0d expected 0", valid_n); end
    endtask

    task automatic test_backpressure();
        logic [15:0] got [0:3];
        logic        lst [0:3];
        int nb = 0;
        int done_k = -1;
        push(16'hAAAA); push(16'hBBBB);
        out_ready = 1'b0;
        start_drain();
        for (int k = 1; k <= 14; k++) begin
            out_ready = (k >= 7);
            @(negedge clk);
            if (k >= 2 && k <= 6) begin
                n_cmp++; if ({out_valid, out_data, stk_delta} !== {1'b1, 16'hBBBB, 2'b00}) begin
                    n_err++; $display("FAIL bp_hold k=%0d: got v=%b d=%h delta=%b expected v=1 d=bbbb delta=00", k, out_valid, out_data, stk_delta);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && nb < 4) begin got[nb] = out_data; lst[nb] = out_last; nb++; end
            if (done === 1'b1 && done_k < 0) done_k = k;
            tick();
        end
        n_cmp++; if (nb !== 2) begin n_err++; $display("FAIL bp_count: got %0d expected 2", nb); end
        n_cmp++; if ({got[0], got[1], lst[0], lst[1]} !== {16'hBBBB, 16'hAAAA, 2'b01}) begin
            n_err++; $display("FAIL bp_beats: got %h %h last %b%b expected bbbb aaaa last 01", got[0], got[1], lst[0], lst[1]);
        end
        n_cmp++; if (done_k !== 12) begin n_err++; $display("FAIL bp_done_cycle: got %0d expected 12", done_k); end
        out_ready = 1'b1;
    endtask

    task automatic test_same_cycle();
        int nb = 0;
        int done_k = -1;
        logic [15:0] got0 = 16'h0000;
        logic        lst0 = 1'b0;
        cpu_we = 1'b1; cpu_delta = 2'b01; cpu_wd = 16'h5555; drain_req = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000; drain_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin if (nb == 0) begin got0 = out_data; lst0 = out_last; end nb++; end
            if (done === 1'b1 && done_k < 0) done_k = k;
            tick();
        end
        n_cmp++; if ({nb[3:0], got0, lst0} !== {4'd1, 16'h5555, 1'b1}) begin
            n_err++; $display("FAIL same_cycle_beat: got n=%0d %h last %b expected n=1 5555 last 1", nb, got0, lst0);
        end
        n_cmp++; if (done_k !== 4) begin n_err++; $display("FAIL same_cycle_done: got %0d expected 4", done_k); end
    endtask

    task automatic test_cpu_ignored();
        logic [15:0] got [0:3];
        int nb = 0;
        int done_k = -1;
        logic [3:0] kk;
        logic [2:0] exp_d;
        push(16'h1234); push(16'h5678);
        start_drain();
        for (int k = 1; k <= 7; k++) begin
            kk = 4'(k);
            cpu_we = kk[0]; cpu_delta = kk[1:0]; cpu_wd = 16'hF0F0 ^ 16'(k);
            exp_d = (k <= 3) ? 3'd2 : ((k <= 6) ? 3'd1 : 3'd0);
            @(negedge clk);
            n_cmp++; if ({stk_we, stk_delta, depth} !== {1'b0, ((k == 3 || k == 6) ? 2'b11 : 2'b00), exp_d}) begin
                n_err++; $display("FAIL ignore_cpu k=%0d: got we=%b delta=%b depth=%0d expected we=0 delta=%b depth=%0d",
                    k, stk_we, stk_delta, depth, ((k == 3 || k == 6) ? 2'b11 : 2'b00), exp_d);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1 && nb < 4) begin got[nb] = out_data; nb++; end
            if (done === 1'b1 && done_k < 0) done_k = k;
            tick();
        end
        cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
        n_cmp++; if ({nb[3:0], got[0], got[1]} !== {4'd2, 16'h5678, 16'h1234}) begin
            n_err++; $display("FAIL ignore_beats: got n=%0d %h %h expected n=2 5678 1234", nb, got[0], got[1]);
        end
        n_cmp++; if (done_k !== 7) begin n_err++; $display("FAIL ignore_done: got %0d expected 7", done_k); end
    endtask

    task automatic test_flags();
        for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
        n_cmp++; if ({depth, ovf, unf} !== {3'd4, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL ovf_push: got depth=%0d ovf=%b unf=%b expected depth=4 ovf=1 unf=0", depth, ovf, unf);
        end
        for (int i = 0; i < 5; i++) cpu_pop(2'b11);
        n_cmp++; if ({depth, ovf, unf} !== {3'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL unf_pop: got depth=%0d ovf=%b unf=%b expected depth=0 ovf=1 unf=1", depth, ovf, unf);
        end
        start_drain();
        tick();
        n_cmp++; if ({ovf, unf} !== 2'b00) begin n_err++; $display("FAIL flags_clear1: got %b expected 00", {ovf, unf}); end
        push(16'h7777);
        cpu_pop(2'b10);
        n_cmp++; if ({depth, unf} !== {3'd0, 1'b1}) begin
            n_err++; $display("FAIL unf_pop2: got depth=%0d unf=%b expected depth=0 unf=1", depth, unf);
        end
        start_drain();
        tick();
        n_cmp++; if ({ovf, unf} !== 2'b00) begin n_err++; $display("FAIL flags_clear2: got %b expected 00", {ovf, unf}); end
    endtask

    task automatic test_reset_mid();
        int done_n = 0;
        push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
        out_ready = 1'b1;
        start_drain();
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++; if ({out_valid, out_data} !== {1'b1, 16'h0B0B}) begin
            n_err++; $display("FAIL mid_offer2: got v=%b d=%h expected v=1 d=0b0b", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, cpu_stall, out_valid, out_last, done, depth, out_data} !== {5'b0, 3'd0, 16'h0000}) begin
            n_err++; $display("FAIL mid_reset: got busy=%b stall=%b v=%b last=%b done=%b depth=%0d d=%h expected all zero",
                busy, cpu_stall, out_valid, out_last, done, depth, out_data);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_n++;
            tick();
        end
        n_cmp++; if (done_n !== 0) begin n_err++; $display("FAIL mid_after: got %0d busy/done cycles expected 0", done_n); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_drain3();
        test_empty_drain();
        test_backpressure();
        test_same_cycle();
        test_cpu_ignored();
        test_flags();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
